// File: rtl/diff_manch_decoder.sv
// -----------------------------------------------------------------------------
// diff_manch_decoder
//
// Receive-side decoder for an IEEE differential Manchester line. The line is
// oversampled on clk, bit timing is recovered purely from the spacing between
// successive line transitions, and one decoded bit is produced per recovered
// bit period.
//
// Decoding rule (line polarity does not matter):
//   - every bit has a transition at mid-bit
//   - a transition at the bit start encodes 0, no transition encodes 1
// So, measured from a mid-bit edge, a 1 shows up as a single LONG interval
// (mid to mid), while a 0 shows up as two SHORT intervals (mid to boundary,
// boundary to mid). A LONG interval can only ever span mid to mid, which is
// what lets the decoder acquire phase from the first 1 bit it sees.
//
// Parameters:
//   HALF_BIT  nominal clk cycles per half-bit on the line (>= 4)
//   TOL       accepted deviation of any interval, in cycles (< HALF_BIT/2)
//
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous, active-high reset
//   d         line input, asynchronous to clk
//   q         decoded bit, meaningful while q_valid is high, holds otherwise
//   q_valid   one-cycle strobe per decoded bit
//   locked    high while the bit phase is known (MID or BND state)
//   err       one-cycle strobe on a coding or timing violation
//
// Latency: a transition first sampled on clk edge N is reflected on the
// outputs updated at edge N+3 (two synchronizer flops, the edge register,
// then the registered classification stage).
// -----------------------------------------------------------------------------
module diff_manch_decoder #(
    parameter int HALF_BIT = 8,
    parameter int TOL      = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic q_valid,
    output logic locked,
    output logic err
);

    // Counter must be able to hold the timeout value 2*HALF_BIT+TOL+1.
    localparam int CNT_W = $clog2(2 * HALF_BIT + TOL + 2);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(2 * HALF_BIT + TOL + 1);
    localparam logic [CNT_W-1:0] SHORT_MIN = CNT_W'(HALF_BIT - TOL);
    localparam logic [CNT_W-1:0] SHORT_MAX = CNT_W'(HALF_BIT + TOL);
    localparam logic [CNT_W-1:0] LONG_MIN  = CNT_W'(2 * HALF_BIT - TOL);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(2 * HALF_BIT + TOL);

    // HUNT: phase unknown; MID: last edge was mid-bit; BND: last edge was a
    // bit boundary.
    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_MID  = 2'd1,
        ST_BND  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IV_SHORT = 2'd0,
        IV_LONG  = 2'd1,
        IV_BAD   = 2'd2
    } iv_class_t;

    // Classify an interval length. The SHORT and LONG windows are disjoint
    // because TOL < HALF_BIT/2.
    function automatic iv_class_t classify(input logic [CNT_W-1:0] len);
        iv_class_t c;
        if ((len >= SHORT_MIN) && (len <= SHORT_MAX)) begin
            c = IV_SHORT;
        end else if ((len >= LONG_MIN) && (len <= LONG_MAX)) begin
            c = IV_LONG;
        end else begin
            c = IV_BAD;
        end
        return c;
    endfunction

    logic             sync1_r;
    logic             sync2_r;
    logic             sync3_r;
    logic             edge_r;
    logic [CNT_W-1:0] cnt_r;
    logic             seen_r;
    state_t           state_r;
    iv_class_t        iv_class_s;

    // Two-flop synchronizer, a third flop for edge detection, and the edge
    // strobe registered so classification sees a stable interval count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            edge_r  <= 1'b0;
        end else begin
            sync1_r <= d;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            edge_r  <= sync2_r ^ sync3_r;
        end
    end

    // Cycles since the last edge strobe. It reads exactly L in the cycle of
    // the next edge strobe, and saturates at the timeout value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (edge_r) begin
            cnt_r <= CNT_ONE;
        end else if (cnt_r != TIMEOUT) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Classification of the interval that an edge strobe terminates.
    always_comb begin
        iv_class_s = IV_BAD;
        iv_class_s = classify(cnt_r);
    end

    // Phase tracking FSM with registered outputs. An edge always takes
    // priority over the timeout when both fall in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_HUNT;
            seen_r  <= 1'b0;
            q       <= 1'b0;
            q_valid <= 1'b0;
            locked  <= 1'b0;
            err     <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            err     <= 1'b0;
            if (edge_r) begin
                // Every edge becomes the reference for the next interval.
                seen_r <= 1'b1;
                case (state_r)
                    ST_HUNT: begin
                        if (!seen_r) begin
                            // First edge only starts the interval counter.
                            state_r <= ST_HUNT;
                        end else if (iv_class_s == IV_LONG) begin
                            q       <= 1'b1;
                            q_valid <= 1'b1;
                            locked  <= 1'b1;
                            state_r <= ST_MID;
                        end else begin
                            // SHORT or BAD: restart timing silently.
                            state_r <= ST_HUNT;
                        end
                    end
                    ST_MID: begin
                        case (iv_class_s)
                            IV_SHORT: begin
                                state_r <= ST_BND;
                            end
                            IV_LONG: begin
                                q       <= 1'b1;
                                q_valid <= 1'b1;
                                state_r <= ST_MID;
                            end
                            default: begin
                                err     <= 1'b1;
                                locked  <= 1'b0;
                                state_r <= ST_HUNT;
                            end
                        endcase
                    end
                    ST_BND: begin
                        if (iv_class_s == IV_SHORT) begin
                            q       <= 1'b0;
                            q_valid <= 1'b1;
                            state_r <= ST_MID;
                        end else begin
                            err     <= 1'b1;
                            locked  <= 1'b0;
                            state_r <= ST_HUNT;
                        end
                    end
                    default: begin
                        locked  <= 1'b0;
                        state_r <= ST_HUNT;
                    end
                endcase
            end else if (cnt_r == TIMEOUT) begin
                // Line went quiet: drop phase; only a locked decoder flags it.
                seen_r <= 1'b0;
                if (state_r != ST_HUNT) begin
                    err     <= 1'b1;
                    locked  <= 1'b0;
                    state_r <= ST_HUNT;
                end else begin
                    state_r <= ST_HUNT;
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule
